// File: rtl/bit_column_scheduler.sv
// bit_column_scheduler: takes one tile of 16 signed weights and 16 signed
// activations and walks the weight bit-columns from MSB to LSB, one beat per
// column. Each beat carries the lane-select mux offsets, slot valid flags,
// per-group activation sums and the column control for the bit-column MAC.
// Optional build macro: SKIP_EMPTY_COL_EN. When it is defined, columns whose
// 16 weight bits are all zero emit no beat.
module bit_column_scheduler #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 16,
    parameter int SUM_ACT_WIDTH = $clog2(VEC_LENGTH) + DATA_WIDTH - 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]     weight,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]     act,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]     act_out,
    output logic [VEC_LENGTH/2-1:0][2:0]              act_sel,
    output logic [VEC_LENGTH/2-1:0]                   act_val,
    output logic [1:0][SUM_ACT_WIDTH-1:0]             sum_act,
    output logic [1:0]                                is_skip_zero,
    output logic [2:0]                                column_idx,
    output logic                                      is_msb,
    output logic                                      load_accum,
    output logic                                      last_col
);

    localparam int GROUP = VEC_LENGTH / 2;   // lanes per group
    localparam int SLOTS = GROUP / 2;        // minority set never exceeds half a group
    localparam int COL_W = 3;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [SLOTS-1:0][2:0] sel;
        logic [SLOTS-1:0]      val;
        logic                  skip;
    } grp_sched_t;

    // Greedy slot packing of the minority lanes of one group for one column.
    function automatic grp_sched_t schedule_group(input logic [GROUP-1:0] bits);
        grp_sched_t       r;
        logic [3:0]       n1;
        logic [GROUP-1:0] minority;
        logic             placed;
        r  = '0;
        n1 = '0;
        for (int i = 0; i < GROUP; i++) n1 = n1 + 4'(bits[i]);
        r.skip   = (n1 <= 4'd4);
        minority = r.skip ? bits : ~bits;
        for (int p = 0; p < GROUP; p++) begin
            placed = 1'b0;
            if (minority[p]) begin
                for (int k = 0; k < SLOTS; k++) begin
                    if (!placed && !r.val[k] && (k + 4 >= p) && (k <= p)) begin
                        r.val[k] = 1'b1;
                        r.sel[k] = 3'(p - k);
                        placed   = 1'b1;
                    end
                end
            end
        end
        return r;
    endfunction

    // Columns that produce a beat: non-empty ones when skipping, else all.
    function automatic logic [DATA_WIDTH-1:0] col_mask(
        input logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] m;
`ifdef SKIP_EMPTY_COL_EN
        m = '0;
        for (int i = 0; i < VEC_LENGTH; i++) m = m | w[i];
`else
        m = w[0] | ~w[0];
`endif
        return m;
    endfunction

    // Highest column in m strictly below limit, as {found, index}.
    function automatic logic [COL_W:0] highest_below(input logic [DATA_WIDTH-1:0] m,
                                                     input logic [COL_W:0]      limit);
        logic [COL_W:0] r;
        r = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (m[i] && (i < int'(limit))) r = {1'b1, COL_W'(i)};
        return r;
    endfunction

    state_t                                  state;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   weight_q;
    logic                                    accept;
    logic                                    fire;
    logic                                    beat_en;

    logic [1:0][SUM_ACT_WIDTH-1:0]           sum_in;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   tgt_w;
    logic [DATA_WIDTH-1:0]                   tgt_mask;
    logic [COL_W-1:0]                        tgt_col;
    logic [COL_W:0]                          first_hit;
    logic [COL_W:0]                          next_hit;
    logic [COL_W:0]                          below_hit;
    logic                                    tgt_last;
    logic [VEC_LENGTH/2-1:0][2:0]            tgt_sel;
    logic [VEC_LENGTH/2-1:0]                 tgt_val;
    logic [1:0]                              tgt_skip;
    logic [GROUP-1:0]                        grp_bits;
    grp_sched_t                              gs;

    assign fire     = out_valid && out_ready;
    assign in_ready = (state == IDLE) || (fire && last_col);
    assign accept   = in_valid && in_ready;
    assign beat_en  = accept || (fire && !last_col);

    // Per-group signed activation sums of the offered tile.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sum_in = '0;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < GROUP; i++)
                sum_in[g] = sum_in[g] + SUM_ACT_WIDTH'($signed(act[GROUP*g+i]));
    end

    // Select the next beat's column and build its slot schedule.
    always_comb begin
        first_hit = highest_below(col_mask(weight), (COL_W+1)'(DATA_WIDTH));
        next_hit  = highest_below(col_mask(weight_q), {1'b0, column_idx});
        if (accept) begin
            tgt_w    = weight;
            tgt_mask = col_mask(weight);
            tgt_col  = first_hit[COL_W] ? first_hit[COL_W-1:0] : '0;
        end else begin
            tgt_w    = weight_q;
            tgt_mask = col_mask(weight_q);
            tgt_col  = next_hit[COL_W-1:0];
        end
        below_hit = highest_below(tgt_mask, {1'b0, tgt_col});
        tgt_last  = !below_hit[COL_W];
        tgt_sel   = '0;
        tgt_val   = '0;
        tgt_skip  = '0;
        grp_bits  = '0;
        gs        = '0;
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < GROUP; i++) grp_bits[i] = tgt_w[GROUP*g+i][tgt_col];
            gs          = schedule_group(grp_bits);
            tgt_skip[g] = gs.skip;
            for (int k = 0; k < SLOTS; k++) begin
                tgt_sel[SLOTS*g+k] = gs.sel[k];
                tgt_val[SLOTS*g+k] = gs.val[k];
            end
        end
    end

    // Tile FSM: accept a tile, run its beats, chain or return to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state     <= IDLE;
            out_valid <= 1'b0;
            weight_q  <= '0;
            act_out   <= '0;
            sum_act   <= '0;
        end else if (accept) begin
            state     <= RUN;
            out_valid <= 1'b1;
            weight_q  <= weight;
            act_out   <= act;
            sum_act   <= sum_in;
        end else if (fire && last_col) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

    // Per-beat outputs: load on acceptance or on a non-final handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_sel      <= '0;
            act_val      <= '0;
            is_skip_zero <= '0;
            column_idx   <= '0;
            is_msb       <= 1'b0;
            load_accum   <= 1'b0;
            last_col     <= 1'b0;
        end else if (beat_en) begin
            act_sel      <= tgt_sel;
            act_val      <= tgt_val;
            is_skip_zero <= tgt_skip;
            column_idx   <= tgt_col;
            is_msb       <= (tgt_col == 3'd7);
            load_accum   <= accept;
            last_col     <= tgt_last;
        end
    end

endmodule

// File: tb/tb_bit_column_scheduler.sv
// tb_bit_column_scheduler: random and directed tiles against a beat-list
// reference model; optional SKIP_EMPTY_COL_EN must match the RTL build.
module tb_bit_column_scheduler;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [15:0][7:0]      weight;
    logic [15:0][7:0]      act;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0][7:0]      act_out;
    logic [7:0][2:0]       act_sel;
    logic [7:0]            act_val;
    logic [1:0][10:0]      sum_act;
    logic [1:0]            is_skip_zero;
    logic [2:0]            column_idx;
    logic                  is_msb;
    logic                  load_accum;
    logic                  last_col;

    bit_column_scheduler dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .weight(weight), .act(act), .out_valid(out_valid), .out_ready(out_ready),
        .act_out(act_out), .act_sel(act_sel), .act_val(act_val), .sum_act(sum_act),
        .is_skip_zero(is_skip_zero), .column_idx(column_idx), .is_msb(is_msb),
        .load_accum(load_accum), .last_col(last_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0][7:0] w;
        logic [15:0][7:0] a;
    } tile_t;

    typedef struct {
        int               tile_id;
        logic [2:0]       col;
        logic [7:0]       val;
        logic [7:0][2:0]  sel;
        logic [1:0]       skip;
        logic             load;
        logic             last;
        logic [15:0][7:0] act;
        logic [1:0][10:0] sum;
    } beat_t;

    tile_t tiles[$];
    beat_t exp_q[$];
    int    beats_seen[int];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Expected beats of a tile, straight from the column/minority/slot rules.
    task automatic build_beats(input tile_t t, input int id);
        int    cols[$];
        beat_t b;
        for (int c = 7; c >= 0; c--) begin
            int ones = 0;
            for (int i = 0; i < 16; i++) ones += int'(t.w[i][c]);
`ifdef SKIP_EMPTY_COL_EN
            if (ones != 0) cols.push_back(c);
`else
            cols.push_back(c);
`endif
        end
        if (cols.size() == 0) cols.push_back(0);
        for (int j = 0; j < cols.size(); j++) begin
            int c = cols[j];
            b.tile_id = id;
            b.col  = 3'(c);
            b.load = (j == 0);
            b.last = (j == cols.size() - 1);
            b.act  = t.a;
            b.val  = '0;
            b.sel  = '0;
            for (int g = 0; g < 2; g++) begin
                int  s = 0;
                int  n1 = 0;
                bit  used[4];
                for (int i = 0; i < 8; i++) begin
                    s  += $signed(t.a[8*g+i]);
                    n1 += int'(t.w[8*g+i][c]);
                end
                b.sum[g]  = 11'(s);
                b.skip[g] = (n1 <= 4);
                for (int k = 0; k < 4; k++) used[k] = 0;
                for (int p = 0; p < 8; p++) begin
                    if (t.w[8*g+p][c] == b.skip[g]) begin
                        for (int k = (p > 4 ? p - 4 : 0); k <= (p < 3 ? p : 3); k++) begin
                            if (!used[k]) begin
                                used[k] = 1;
                                b.val[4*g+k] = 1'b1;
                                b.sel[4*g+k] = 3'(p - k);
                                break;
                            end
                        end
                    end
                end
            end
            exp_q.push_back(b);
        end
    endtask

    tile_t cur;
    bit    offering;
    int    tid_next;
    int    cyc;

    initial begin
        tile_t t;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        weight = '0; act = '0; offering = 0; tid_next = 0;

        // Tile 0: all weights 1, act[i] = i.
        for (int i = 0; i < 16; i++) begin t.w[i] = 8'h01; t.a[i] = 8'(i); end
        tiles.push_back(t);
        // Tile 1: group 0 bit 3 only in lanes 5,6,7.
        for (int i = 0; i < 16; i++) begin
            t.a[i] = 8'($urandom);
            t.w[i] = 8'($urandom);
            if (i < 5)      t.w[i] = t.w[i] & 8'hF7;
            else if (i < 8) t.w[i] = t.w[i] | 8'h08;
        end
        tiles.push_back(t);
        // Tile 2: all activations -128.
        for (int i = 0; i < 16; i++) begin t.w[i] = 8'($urandom); t.a[i] = 8'h80; end
        tiles.push_back(t);
        // Tile 3: all weights zero.
        for (int i = 0; i < 16; i++) begin t.w[i] = 8'h00; t.a[i] = 8'($urandom); end
        tiles.push_back(t);
        // Random tiles, some with sparse column usage.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] cm;
            cm = 8'($urandom);
            if ($urandom_range(0, 2) == 0) cm = cm & 8'($urandom);
            for (int i = 0; i < 16; i++) begin
                t.w[i] = 8'($urandom) & cm;
                t.a[i] = 8'($urandom);
            end
            tiles.push_back(t);
        end

        // Reset held low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_column_idx", column_idx, 3'd0);
        check("rst_act_val", act_val, 8'h00);
        check("rst_act_sel", act_sel, 24'h0);
        check("rst_sum_act", sum_act, 22'h0);
        check("rst_act_out", act_out, 128'h0);
        check("rst_flags", {is_skip_zero, is_msb, load_accum, last_col}, 5'b0);
        reset = 1'b1;

        cyc = 0;
        while ((tiles.size() > 0 || offering || exp_q.size() > 0) && cyc < 20000) begin
            @(posedge clk);
            #1;
            if (!offering && tiles.size() > 0 && (tid_next < 4 || $urandom_range(0, 1) == 1)) begin
                cur = tiles.pop_front();
                offering = 1;
            end
            in_valid = offering;
            if (offering) begin weight = cur.w; act = cur.a; end
            else begin weight = {4{32'($urandom)}}; act = {4{32'($urandom)}}; end
            if (cyc >= 4 && cyc < 7) out_ready = 1'b0;
            else if (tid_next <= 4)  out_ready = 1'b1;
            else                     out_ready = ($urandom_range(0, 3) != 0);

            @(negedge clk);
            begin
                bit exp_v;
                bit exp_last;
                exp_v    = (exp_q.size() != 0);
                exp_last = exp_v && exp_q[0].last;
                check("out_valid", out_valid, exp_v);
                check("in_ready", in_ready, !exp_v || (out_ready && exp_last));
                if (out_valid && exp_v) begin
                    beat_t e;
                    e = exp_q[0];
                    check("column_idx", column_idx, e.col);
                    check("is_msb", is_msb, e.col == 3'd7);
                    check("load_accum", load_accum, e.load);
                    check("last_col", last_col, e.last);
                    check("act_val", act_val, e.val);
                    check("act_sel", act_sel, e.sel);
                    check("is_skip_zero", is_skip_zero, e.skip);
                    check("sum_act", sum_act, e.sum);
                    check("act_out", act_out, e.act);
                    if (e.tile_id == 0)
                        check("t0_sum_act", sum_act, {11'd92, 11'd28});
                    if (e.tile_id == 2)
                        check("t2_sum_act", sum_act, {11'h400, 11'h400});
                    if (e.tile_id == 1 && e.col == 3'd3) begin
                        check("t1_col3_val", act_val[3:0], 4'b1110);
                        check("t1_col3_sel", act_sel[3:0], {3'd4, 3'd4, 3'd4, 3'd0});
                    end
                    if (out_ready) begin
                        beats_seen[e.tile_id] = beats_seen.exists(e.tile_id)
                                              ? beats_seen[e.tile_id] + 1 : 1;
                        void'(exp_q.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    build_beats(cur, tid_next);
                    tid_next++;
                    offering = 0;
                end
            end
            cyc++;
        end
        check("timeout", cyc < 20000, 1'b1);
        in_valid = 1'b0;

        check("t0_beats", beats_seen.exists(0) ? beats_seen[0] : 0,
`ifdef SKIP_EMPTY_COL_EN
              1
`else
              8
`endif
        );
        check("t3_beats", beats_seen.exists(3) ? beats_seen[3] : 0,
`ifdef SKIP_EMPTY_COL_EN
              1
`else
              8
`endif
        );

        // Reset mid-tile abandons the tile.
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin weight[i] = 8'hFF; act[i] = 8'($urandom); end
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", out_valid, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_column_idx", column_idx, 3'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_no_beats", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
